step_pulse_gen: RTL and testbench

- Upstream neighbour of the processor: turns the synchronized step key into exactly one single-cycle step pulse per press.
- The step pulse is the processor's advance strobe.
- Adds debounce, a saturating-free step counter for display, and an optional auto-run mode that emits periodic steps.
- Sits between the key synchronizer and the processor; Step drives the processor's step/clock-enable input.

---
 rtl/step_pkg.sv | 15 +
 rtl/step_pulse_gen_if.sv | 22 ++
 rtl/step_pulse_gen_stable_counter.sv | 29 ++
 rtl/step_pulse_gen.sv | 120 ++++++++++++
 tb/tb_step_pulse_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared FSM state type and default timing constants for step_pulse_gen
package step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } step_state_t;

  localparam int DEBOUNCE_DEFAULT    = 500000;
  localparam int AUTO_PERIOD_DEFAULT = 25000000;
  localparam int CNT_W_DEFAULT       = 16;

endpackage

// File: rtl/step_pulse_gen_if.sv
// rtl/step_pulse_gen_if.sv - key/run inputs and step outputs of step_pulse_gen
interface step_pulse_gen_if #(
  parameter int CNT_W = 16
);

  logic             KeyIn;
  logic             Run;
  logic             Step;
  logic             Pressed;
  logic [CNT_W-1:0] StepCount;

  modport master (
    output KeyIn, Run,
    input  Step, Pressed, StepCount
  );

  modport slave (
    input  KeyIn, Run,
    output Step, Pressed, StepCount
  );

endinterface

// File: rtl/step_pulse_gen_stable_counter.sv
// rtl/step_pulse_gen_stable_counter.sv - counts consecutive enabled cycles; done on the THRESH-th one
module stable_counter #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = $clog2(THRESH + 1);

  logic [W-1:0] cnt;

  // done is combinational so the owner can change state on the same edge
  assign done = enable && (cnt == W'(THRESH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - debounced one-pulse-per-press step strobe with wrapping step counter
// Optional periodic auto-run stepping while idle is compiled in with STEP_AUTORUN_EN.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int AUTO_PERIOD     = AUTO_PERIOD_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input logic             CLOCK_50,
  input logic             Reset,
  step_pulse_gen_if.slave io
);

  step_state_t      state;
  logic             step_r;
  logic             pressed_r;
  logic [CNT_W-1:0] count;

  logic db_en;
  logic db_clr;
  logic db_done;
  logic manual_fire;
  logic auto_fire;

  // The counter only runs while the key sits at the level the wait state is qualifying,
  // so every state entry and every bounce restarts it from zero.
  assign db_en  = ((state == PRESS_WAIT) && io.KeyIn) ||
                  ((state == RELEASE_WAIT) && !io.KeyIn);
  assign db_clr = !db_en || db_done;

  stable_counter #(
    .THRESH (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (CLOCK_50),
    .rst    (Reset),
    .clear  (db_clr),
    .enable (db_en),
    .done   (db_done)
  );

  assign manual_fire = (state == PRESS_WAIT) && db_done;

`ifdef STEP_AUTORUN_EN
  localparam int AW = $clog2(AUTO_PERIOD + 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_run;
  logic          auto_tc;

  // A pending key press leaves IDLE on this edge, so it takes priority over auto-run.
  assign auto_run  = (state == IDLE) && io.Run && !io.KeyIn;
  assign auto_tc   = auto_cnt == AW'(AUTO_PERIOD - 1);
  assign auto_fire = auto_run && auto_tc && !step_r;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      auto_cnt <= '0;
    end else if (!auto_run || auto_tc) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  wire unused_run = io.Run;

  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      step_r    <= 1'b0;
      pressed_r <= 1'b0;
      count     <= '0;
    end else begin
      step_r <= manual_fire || auto_fire;
      if (manual_fire || auto_fire) begin
        count <= count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (io.KeyIn) begin
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!io.KeyIn) begin
            state <= IDLE;
          end else if (db_done) begin
            state     <= HELD;
            pressed_r <= 1'b1;
          end
        end
        HELD: begin
          if (!io.KeyIn) begin
            state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (io.KeyIn) begin
            state <= HELD;
          end else if (db_done) begin
            state     <= IDLE;
            pressed_r <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.Step      = step_r;
  assign io.Pressed   = pressed_r;
  assign io.StepCount = count;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - directed scoreboard bench for step_pulse_gen (DEBOUNCE 4, AUTO 10, CNT_W 4)
module tb_step_pulse_gen;

  logic clk = 1'b0;
  logic rst;

  step_pulse_gen_if #(.CNT_W(4)) bus ();

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (10),
    .CNT_W           (4)
  ) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .io       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       head;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_cnt = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected Step lands dly posedges after the current (negedge) drive point.
  task automatic expect_step(input int dly);
    model_cnt = model_cnt + 4'd1;
    sb.push_back('{cyc + dly, model_cnt});
  endtask

  task automatic press_release();
    bus.KeyIn = 1'b1;
    expect_step(5);
    repeat (6) @(negedge clk);
    bus.KeyIn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.Step === 1'b1) begin
      check("step_was_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        head = sb.pop_front();
        check("step_cycle", cyc, head.at);
        check("step_count", bus.StepCount, head.cnt);
      end
    end
  end

  logic bp[8];
  logic rb[6];

  initial begin
    bp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rst       = 1'b1;
    bus.KeyIn = 1'b0;
    bus.Run   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_step", bus.Step, 0);
    check("reset_pressed", bus.Pressed, 0);
    check("reset_count", bus.StepCount, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // clean press: held 20 cycles, released 10
    bus.KeyIn = 1'b1;
    expect_step(5);
    repeat (4) @(negedge clk);
    check("pressed_before_debounce", bus.Pressed, 0);
    @(negedge clk);
    check("pressed_after_debounce", bus.Pressed, 1);
    repeat (15) @(negedge clk);
    bus.KeyIn = 1'b0;
    repeat (4) @(negedge clk);
    check("pressed_during_release_wait", bus.Pressed, 1);
    @(negedge clk);
    check("pressed_after_release", bus.Pressed, 0);
    repeat (5) @(negedge clk);
    check("count_after_clean", bus.StepCount, model_cnt);

    // press bounce: the 0 restarts debounce from the following 1
    for (int i = 0; i < 8; i++) begin
      if (i == 3) expect_step(5);
      bus.KeyIn = bp[i];
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("pressed_after_bounce", bus.Pressed, 1);
    bus.KeyIn = 1'b0;
    repeat (7) @(negedge clk);

    // release bounce: the 1 returns to HELD, no second step
    bus.KeyIn = 1'b1;
    expect_step(5);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.KeyIn = rb[i];
      @(negedge clk);
      check("pressed_through_release_bounce", bus.Pressed, 1);
    end
    @(negedge clk);
    check("pressed_after_release_bounce", bus.Pressed, 0);
    repeat (3) @(negedge clk);

    // async reset mid-PRESS_WAIT with key still held
    bus.KeyIn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_step", bus.Step, 0);
    check("async_reset_pressed", bus.Pressed, 0);
    check("async_reset_count", bus.StepCount, 0);
    #4 rst = 1'b0;
    model_cnt = 4'd0;
    expect_step(5);
    @(negedge clk);
    repeat (8) @(negedge clk);
    bus.KeyIn = 1'b0;
    repeat (7) @(negedge clk);

    // wrap: 16 presses from zero
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 4'd0;
    check("count_before_wrap", bus.StepCount, 0);
    for (int i = 0; i < 16; i++) press_release();
    check("count_after_wrap", bus.StepCount, model_cnt);

`ifdef STEP_AUTORUN_EN
    bus.Run = 1'b1;
    expect_step(10);
    expect_step(20);
    expect_step(30);
    repeat (35) @(negedge clk);
    bus.Run = 1'b0;
    repeat (3) @(negedge clk);

    // key mid-run clears the auto counter; auto resumes a full period after returning to IDLE
    bus.Run = 1'b1;
    repeat (3) @(negedge clk);
    bus.KeyIn = 1'b1;
    expect_step(5);
    expect_step(21);
    repeat (6) @(negedge clk);
    bus.KeyIn = 1'b0;
    repeat (16) @(negedge clk);
    bus.Run = 1'b0;
    repeat (3) @(negedge clk);
    check("count_after_autorun", bus.StepCount, model_cnt);
`else
    bus.Run = 1'b1;
    repeat (35) @(negedge clk);
    bus.Run = 1'b0;
    repeat (3) @(negedge clk);
    check("count_run_ignored", bus.StepCount, model_cnt);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
